// File: rtl/gf2_kara_seq.sv
// 8x8 carry-less multiplier built from one time-shared 4x4 core (Karatsuba, 3 partial products).
// Optional reduction modulo x^8 + POLY enabled by defining KARA_REDUCE_EN.
module gf2_kara_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);

`ifdef KARA_REDUCE_EN
  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_RED, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_DONE} state_t;
`endif

  state_t      state_q;
  logic [7:0]  a_q, b_q;
  logic [7:0]  d0_q, d1_q, d2_q;
  logic [15:0] product_q;
  logic        out_valid_q;

  logic [3:0]  mul_x_d, mul_y_d;
  logic [7:0]  mul_res_d;
  logic [7:0]  mid_d;
  logic [15:0] kara_d;

  function automatic logic [7:0] clmul4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) r = r ^ ({4'h0, x} << i);
    end
    return r;
  endfunction

`ifdef KARA_REDUCE_EN
  // Fold bits 14..8 down one at a time; x^8 == POLY in the field.
  function automatic logic [15:0] reduce(input logic [15:0] p);
    logic [15:0] r;
    r = p;
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ {1'b1, POLY};
    end
    return {8'h00, r[7:0]};
  endfunction
`else
  logic unused_poly;
  assign unused_poly = ^POLY;
`endif

  // The single shared multiplier: operand halves selected by the current step.
  always_comb begin
    mul_x_d = a_q[3:0];
    mul_y_d = b_q[3:0];
    case (state_q)
      S_P1: begin
        mul_x_d = a_q[3:0] ^ a_q[7:4];
        mul_y_d = b_q[3:0] ^ b_q[7:4];
      end
      S_P2: begin
        mul_x_d = a_q[7:4];
        mul_y_d = b_q[7:4];
      end
      default: ;
    endcase
  end

  assign mul_res_d = clmul4(mul_x_d, mul_y_d);
  assign mid_d     = mul_res_d ^ d1_q ^ d0_q;
  assign kara_d    = {mul_res_d[7:4], mul_res_d[3:0] ^ mid_d[7:4],
                      d0_q[7:4] ^ mid_d[3:0], d0_q[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      d0_q        <= 8'h00;
      d1_q        <= 8'h00;
      d2_q        <= 8'h00;
      product_q   <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            state_q <= S_P0;
          end
        end
        S_P0: begin
          d0_q    <= mul_res_d;
          state_q <= S_P1;
        end
        S_P1: begin
          d1_q    <= mul_res_d;
          state_q <= S_P2;
        end
        S_P2: begin
          d2_q      <= mul_res_d;
          product_q <= kara_d;
`ifdef KARA_REDUCE_EN
          state_q   <= S_RED;
`else
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
`endif
        end
`ifdef KARA_REDUCE_EN
        S_RED: begin
          product_q   <= reduce(product_q);
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
